// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue and the predictor update (BrInfo) interface.
package branch_resolve_queue_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned BRQ_DEPTH  = 8;
    localparam int unsigned BRQ_HIST_W = 10;
    localparam int unsigned BRQ_TAG_W  = $clog2(BRQ_DEPTH);

    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        logic  valid;
        addr_t pc;
        logic  taken;
        addr_t target;
    } br_info_t;

    typedef struct packed {
        addr_t                 pc;
        logic                  pred_taken;
        logic [BRQ_HIST_W-1:0] hist;
        logic                  taken;
        addr_t                 target;
    } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue.sv
// In-order retire queue for predicted branches: allocate at fetch, resolve by tag in any
// order, retire one entry per cycle as a registered BrInfo carrying the fetch-time history.
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = BRQ_DEPTH,
    parameter int unsigned WIDTH_HIST = BRQ_HIST_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     fetch_valid,
    input  addr_t                    fetch_pc,
    input  logic                     fetch_pred_taken,
    input  logic [WIDTH_HIST-1:0]    fetch_hist,
    output logic                     fetch_ready,
    output logic [$clog2(DEPTH)-1:0] fetch_tag,
    input  logic                     res_valid,
    input  logic [$clog2(DEPTH)-1:0] res_tag,
    input  logic                     res_taken,
    input  addr_t                    res_target,
    output br_info_t                 brinfo,
    output logic [WIDTH_HIST-1:0]    brinfo_hist,
    output logic                     mispredict
);

    localparam int unsigned TAG_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = TAG_W + 1;

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [DEPTH-1:0] resolved;
    brq_entry_t       entries [DEPTH];

    logic [TAG_W-1:0] res_offset_c;
    logic             res_live_c;
    logic             head_bypass_c;
    logic             retire_c;
    logic             ret_taken_c;
    addr_t            ret_target_c;
    logic             mispredict_c;
    logic             push_c;
    logic [DEPTH-1:0] resolved_nxt_c;

    // Derived from state only so fetch never sees a same-cycle retire as a free slot.
    assign fetch_ready = (count < CNT_W'(DEPTH));
    assign fetch_tag   = tail;

    // Resolve window, head bypass, retire and push qualification.
    always_comb begin
        res_offset_c   = res_tag - head;
        res_live_c     = res_valid && !flush && (CNT_W'(res_offset_c) < count);
        head_bypass_c  = res_live_c && (res_tag == head);
        retire_c       = !flush && (count != '0) && (resolved[head] || head_bypass_c);
        ret_taken_c    = head_bypass_c ? res_taken  : entries[head].taken;
        ret_target_c   = head_bypass_c ? res_target : entries[head].target;
        mispredict_c   = retire_c && (ret_taken_c != entries[head].pred_taken);
        push_c         = fetch_valid && fetch_ready && !flush && !mispredict_c;

        resolved_nxt_c = resolved;
        if (res_live_c) begin
            resolved_nxt_c[res_tag] = 1'b1;
        end
        if (retire_c) begin
            resolved_nxt_c[head] = 1'b0;
        end
        if (push_c) begin
            resolved_nxt_c[tail] = 1'b0;
        end
    end

    // Pointers, occupancy and registered retire outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            resolved    <= '0;
            brinfo      <= '0;
            brinfo_hist <= '0;
            mispredict  <= 1'b0;
        end else if (flush) begin
            head         <= tail;
            count        <= '0;
            resolved     <= '0;
            brinfo.valid <= 1'b0;
            mispredict   <= 1'b0;
        end else begin
            mispredict <= mispredict_c;
            if (retire_c) begin
                brinfo      <= '{valid: 1'b1, pc: entries[head].pc,
                                 taken: ret_taken_c, target: ret_target_c};
                brinfo_hist <= WIDTH_HIST'(entries[head].hist);
            end else begin
                brinfo.valid <= 1'b0;
            end

            // A mispredicted retire squashes every younger entry and the same-cycle fetch.
            if (mispredict_c) begin
                head     <= head + TAG_W'(1);
                tail     <= head + TAG_W'(1);
                count    <= '0;
                resolved <= '0;
            end else begin
                head     <= head + TAG_W'(retire_c);
                tail     <= tail + TAG_W'(push_c);
                count    <= count + CNT_W'(push_c) - CNT_W'(retire_c);
                resolved <= resolved_nxt_c;
            end
        end
    end

    // Entry payload storage; liveness is tracked by head/count so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push_c) begin
            entries[tail] <= '{pc: fetch_pc, pred_taken: fetch_pred_taken,
                               hist: BRQ_HIST_W'(fetch_hist), taken: 1'b0, target: '0};
        end
        if (res_live_c) begin
            entries[res_tag].taken  <= res_taken;
            entries[res_tag].target <= res_target;
        end
    end

endmodule
